// File: rtl/if_ctrl_pkg.sv
// Shared encodings for the instruction-fetch program controller.
// Pure declarations: no logic, no latency, no flow control.
package if_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_RUN    = 3'd2,
        ST_STEP   = 3'd3,
        ST_HALTED = 3'd4
    } state_e;

    localparam logic [7:0] CMD_LOAD = 8'h4C;
    localparam logic [7:0] CMD_CONT = 8'h43;
    localparam logic [7:0] CMD_STEP = 8'h53;
    localparam logic [7:0] CMD_NEXT = 8'h4E;
    localparam logic [7:0] CMD_RET  = 8'h52;

    localparam logic [31:0] HALT_INST_DFLT = 32'hFFFF_FFFF;

endpackage

// File: rtl/if_prog_ctrl_if.sv
// Host-stream, instruction-memory write port and fetch-enable bundle of the controller.
// Wires only; master is the controller side, slave the surrounding datapath/host.
interface if_prog_ctrl_if #(
    parameter int NB_ADDR = 32,
    parameter int NB_INST = 32,
    parameter int NB_BYTE = 8
);
    logic [NB_BYTE-1:0] i_rx_data;
    logic               i_rx_valid;
    logic [NB_INST-1:0] i_fetched_inst;
    logic               o_write;
    logic [NB_INST-1:0] o_instruction;
    logic [NB_ADDR-1:0] o_address;
    logic               o_enable;
    logic [2:0]         o_state;
    logic               o_load_err;

    modport master (
        input  i_rx_data, i_rx_valid, i_fetched_inst,
        output o_write, o_instruction, o_address, o_enable, o_state, o_load_err
    );

    modport slave (
        output i_rx_data, i_rx_valid, i_fetched_inst,
        input  o_write, o_instruction, o_address, o_enable, o_state, o_load_err
    );
endinterface

// File: rtl/if_prog_ctrl_word_asm.sv
// Little-endian byte-to-word assembler; word_done/word_dat are valid combinationally with the last byte.
// Latency: 0 cycles to the done pulse; backpressure: none, every valid byte is taken.
module if_word_asm #(
    parameter int NB_BYTE = 8,
    parameter int NB_INST = 32
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_clr,
    input  logic               i_byte_vld,
    input  logic [NB_BYTE-1:0] i_byte_dat,
    output logic               o_word_done,
    output logic [NB_INST-1:0] o_word_dat
);
    localparam int BYTES = NB_INST / NB_BYTE;
    localparam int CW    = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam int SW    = NB_INST - NB_BYTE;

    logic [CW-1:0] byte_cnt_q, byte_cnt_d;
    logic [SW-1:0] shift_q, shift_d;

    // Bytes enter at the top and move down, so the first byte ends up in the LSBs.
    assign o_word_done = i_byte_vld && (byte_cnt_q == CW'(BYTES - 1));
    assign o_word_dat  = {i_byte_dat, shift_q};

    always_comb begin
        byte_cnt_d = byte_cnt_q;
        shift_d    = shift_q;
        if (i_clr) begin
            byte_cnt_d = '0;
        end else if (i_byte_vld) begin
            byte_cnt_d = o_word_done ? '0 : byte_cnt_q + CW'(1);
            shift_d    = {i_byte_dat, shift_q[SW-1:NB_BYTE]};
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            byte_cnt_q <= '0;
            shift_q    <= '0;
        end else begin
            byte_cnt_q <= byte_cnt_d;
            shift_q    <= shift_d;
        end
    end
endmodule

// File: rtl/if_prog_ctrl.sv
// Loads a program into instruction memory from the host byte stream, then gates the fetch stage (run/step).
// Latency: all outputs registered, 1 cycle after the triggering byte/fetch; backpressure: none, unlisted bytes dropped.
module if_prog_ctrl
    import if_ctrl_pkg::*;
#(
    parameter int          NB_ADDR   = 32,
    parameter int          NB_INST   = 32,
    parameter int          NB_BYTE   = 8,
    parameter int          MEM_WORDS = 256,
    parameter logic [31:0] HALT_INST = HALT_INST_DFLT
) (
    input  logic           i_clk,
    input  logic           i_reset,
    if_prog_ctrl_if.master bus
);
    localparam int WCW = $clog2(MEM_WORDS) + 1;
    localparam logic [NB_INST-1:0] HALT_W = NB_INST'(HALT_INST);

    state_e             state_q, state_d;
    logic [WCW-1:0]     wcnt_q, wcnt_d;
    logic               write_q, write_d;
    logic [NB_INST-1:0] inst_q, inst_d;
    logic [NB_ADDR-1:0] addr_q, addr_d;
    logic               en_q, en_d;
    logic               err_q, err_d;

    logic               asm_clr, asm_vld, word_done;
    logic [NB_INST-1:0] word_dat;
    logic               fetched_halt;

    assign asm_clr      = (state_q == ST_IDLE) && bus.i_rx_valid && (bus.i_rx_data == NB_BYTE'(CMD_LOAD));
    assign asm_vld      = (state_q == ST_LOAD) && bus.i_rx_valid;
    assign fetched_halt = (bus.i_fetched_inst == HALT_W);

    if_word_asm #(.NB_BYTE(NB_BYTE), .NB_INST(NB_INST)) u_asm (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_clr       (asm_clr),
        .i_byte_vld  (asm_vld),
        .i_byte_dat  (bus.i_rx_data),
        .o_word_done (word_done),
        .o_word_dat  (word_dat)
    );

    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        write_d = 1'b0;
        inst_d  = inst_q;
        addr_d  = addr_q;
        en_d    = 1'b0;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.i_rx_valid) begin
                    if (bus.i_rx_data == NB_BYTE'(CMD_LOAD)) begin
                        state_d = ST_LOAD;
                        err_d   = 1'b0;
                        wcnt_d  = '0;
                    end else if (bus.i_rx_data == NB_BYTE'(CMD_CONT)) begin
                        state_d = ST_RUN;
                        en_d    = 1'b1;
                    end else if (bus.i_rx_data == NB_BYTE'(CMD_STEP)) begin
                        state_d = ST_STEP;
                    end
                end
            end
            ST_LOAD: begin
                if (word_done) begin
                    write_d = 1'b1;
                    inst_d  = word_dat;
                    addr_d  = NB_ADDR'(wcnt_q) << 2;
                    wcnt_d  = wcnt_q + WCW'(1);
                    if (word_dat == HALT_W) begin
                        state_d = ST_IDLE;
                    end else if (wcnt_q == WCW'(MEM_WORDS - 1)) begin
                        // Memory full: stop here rather than wrap onto word 0.
                        err_d   = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_RUN: begin
                if (fetched_halt) state_d = ST_HALTED;
                else              en_d    = 1'b1;
            end
            ST_STEP: begin
                // While a step is in flight the fetched word is stale, so halt is only trusted when idle.
                if (!en_q && fetched_halt) begin
                    state_d = ST_HALTED;
                end else if (bus.i_rx_valid && (bus.i_rx_data == NB_BYTE'(CMD_NEXT))) begin
                    en_d = 1'b1;
                end
            end
            ST_HALTED: begin
                if (bus.i_rx_valid && (bus.i_rx_data == NB_BYTE'(CMD_RET))) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q <= ST_IDLE;
            wcnt_q  <= '0;
            write_q <= 1'b0;
            inst_q  <= '0;
            addr_q  <= '0;
            en_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            write_q <= write_d;
            inst_q  <= inst_d;
            addr_q  <= addr_d;
            en_q    <= en_d;
            err_q   <= err_d;
        end
    end

    assign bus.o_write       = write_q;
    assign bus.o_instruction = inst_q;
    assign bus.o_address     = addr_q;
    assign bus.o_enable      = en_q;
    assign bus.o_state       = state_q;
    assign bus.o_load_err    = err_q;
endmodule

// File: tb/tb_if_prog_ctrl.sv
// Directed bench for if_prog_ctrl: load, overflow, run, step, halt/return and async reset.
module tb_if_prog_ctrl;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    if_prog_ctrl_if #(.NB_ADDR(32), .NB_INST(32), .NB_BYTE(8)) bus ();

    if_prog_ctrl #(
        .NB_ADDR(32), .NB_INST(32), .NB_BYTE(8), .MEM_WORDS(4), .HALT_INST(32'hFFFF_FFFF)
    ) dut (
        .i_clk   (clk),
        .i_reset (rst_n),
        .bus     (bus.master)
    );

    int n_checks = 0;
    int n_errors = 0;
    int en_cnt   = 0;
    int both_cnt = 0;
    logic [63:0] wr_q[$];

    always @(negedge clk) begin
        if (bus.o_write) wr_q.push_back({bus.o_address, bus.o_instruction});
        if (bus.o_enable) en_cnt++;
        if (bus.o_write && bus.o_enable) both_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        bus.i_rx_data  = b;
        bus.i_rx_valid = 1'b1;
        @(negedge clk);
        bus.i_rx_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    initial begin
        int base, en_base;
        bus.i_rx_data      = 8'h00;
        bus.i_rx_valid     = 1'b0;
        bus.i_fetched_inst = 32'h0000_0013;
        idle(2);
        chk("rst_state", 32'(bus.o_state), 32'd0);
        chk("rst_write", 32'(bus.o_write), 32'd0);
        chk("rst_enable", 32'(bus.o_enable), 32'd0);
        chk("rst_addr", bus.o_address, 32'd0);
        chk("rst_inst", bus.o_instruction, 32'd0);
        chk("rst_err", 32'(bus.o_load_err), 32'd0);
        rst_n = 1'b1;

        // Unknown byte in IDLE is ignored
        send_byte(8'h00);
        chk("idle_ignore_state", 32'(bus.o_state), 32'd0);

        // Two-word program ending in halt
        base = wr_q.size();
        send_byte(8'h4C);
        chk("load_enter", 32'(bus.o_state), 32'd1);
        send_word(32'h0100_0820);
        chk("ld1_write", 32'(bus.o_write), 32'd1);
        chk("ld1_inst", bus.o_instruction, 32'h0100_0820);
        chk("ld1_addr", bus.o_address, 32'd0);
        chk("ld1_state", 32'(bus.o_state), 32'd1);
        idle(1);
        chk("ld1_pulse_end", 32'(bus.o_write), 32'd0);
        chk("ld1_inst_hold", bus.o_instruction, 32'h0100_0820);
        send_word(32'hFFFF_FFFF);
        chk("ld2_write", 32'(bus.o_write), 32'd1);
        chk("ld2_inst", bus.o_instruction, 32'hFFFF_FFFF);
        chk("ld2_addr", bus.o_address, 32'd4);
        chk("ld2_state", 32'(bus.o_state), 32'd0);
        chk("ld2_err", 32'(bus.o_load_err), 32'd0);
        idle(2);
        chk("ld_nwrites", 32'(wr_q.size() - base), 32'd2);

        // Overflow with MEM_WORDS=4: word bytes avoid command codes
        base = wr_q.size();
        send_byte(8'h4C);
        for (int k = 0; k < 5; k++) begin
            send_word(32'h4030_2010 + 32'(k));
            if (k == 3) begin
                chk("ovf_addr3", bus.o_address, 32'd12);
                chk("ovf_err", 32'(bus.o_load_err), 32'd1);
                chk("ovf_state", 32'(bus.o_state), 32'd0);
            end
        end
        idle(2);
        chk("ovf_nwrites", 32'(wr_q.size() - base), 32'd4);
        for (int k = 0; k < 4 && base + k < wr_q.size(); k++) begin
            chk("ovf_wr_addr", wr_q[base+k][63:32], 32'(4 * k));
            chk("ovf_wr_inst", wr_q[base+k][31:0], 32'h4030_2010 + 32'(k));
        end
        chk("ovf_err_sticky", 32'(bus.o_load_err), 32'd1);
        send_byte(8'h4C);
        chk("reload_clr_err", 32'(bus.o_load_err), 32'd0);
        send_word(32'hFFFF_FFFF);
        chk("reload_addr0", bus.o_address, 32'd0);

        // Continuous run: 10 enabled cycles, then halt
        send_byte(8'h43);
        chk("run_state", 32'(bus.o_state), 32'd2);
        chk("run_en0", 32'(bus.o_enable), 32'd1);
        for (int i = 1; i < 10; i++) begin
            @(negedge clk);
            chk("run_en", 32'(bus.o_enable), 32'd1);
        end
        bus.i_fetched_inst = 32'hFFFF_FFFF;
        @(negedge clk);
        chk("run_halt_en", 32'(bus.o_enable), 32'd0);
        chk("run_halt_state", 32'(bus.o_state), 32'd4);

        // HALTED ignores 'C', returns on 'R'
        bus.i_fetched_inst = 32'h0000_0013;
        send_byte(8'h43);
        chk("halt_ignore_state", 32'(bus.o_state), 32'd4);
        chk("halt_ignore_en", 32'(bus.o_enable), 32'd0);
        send_byte(8'h52);
        chk("ret_state", 32'(bus.o_state), 32'd0);

        // Single step
        send_byte(8'h53);
        chk("step_state", 32'(bus.o_state), 32'd3);
        chk("step_idle_en", 32'(bus.o_enable), 32'd0);
        en_base = en_cnt;
        for (int p = 0; p < 3; p++) begin
            send_byte(8'h4E);
            chk("step_pulse", 32'(bus.o_enable), 32'd1);
            @(negedge clk);
            chk("step_pulse_end", 32'(bus.o_enable), 32'd0);
            idle(3);
        end
        @(negedge clk);
        bus.i_fetched_inst = 32'hFFFF_FFFF;
        bus.i_rx_data      = 8'h4E;
        bus.i_rx_valid     = 1'b1;
        @(negedge clk);
        bus.i_rx_valid = 1'b0;
        chk("step_halt_en", 32'(bus.o_enable), 32'd0);
        chk("step_halt_state", 32'(bus.o_state), 32'd4);
        idle(2);
        chk("step_npulses", 32'(en_cnt - en_base), 32'd3);
        chk("no_write_with_en", 32'(both_cnt), 32'd0);

        // Async reset in the middle of a run with a nonzero address
        bus.i_fetched_inst = 32'h0000_0013;
        send_byte(8'h52);
        send_byte(8'h4C);
        send_word(32'h1122_3344);
        send_word(32'hFFFF_FFFF);
        chk("pre_rst_addr", bus.o_address, 32'd4);
        send_byte(8'h43);
        chk("pre_rst_en", 32'(bus.o_enable), 32'd1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_en", 32'(bus.o_enable), 32'd0);
        chk("arst_state", 32'(bus.o_state), 32'd0);
        chk("arst_addr", bus.o_address, 32'd0);
        chk("arst_inst", bus.o_instruction, 32'd0);
        idle(2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
